alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
- Execute-stage controller wrapped around the 8-bit ALU.
- Accepts one 8-bit instruction at a time over a valid/ready handshake and reads two operands from an internal 4x8 register file.
- Drives the ALU's a/b/op inputs, captures the ALU result and flags, then writes the result back to the register file and a flags register.
- Sits between the instruction decoder (upstream) and the ALU (combinational, downstream).

Parameters:
- REG_RESET, 8'h00, reset value loaded into all four registers R0..R3.
- DATA_W, 8, datapath width; only 8 is supported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE.
- instr  in  8  [7:4]=opcode, [3:2]=rd, [1:0]=rs.
- alu_a  out  8  operand A to ALU.
- alu_b  out  8  operand B to ALU.
- alu_op  out  4  opcode to ALU.
- alu_out  in  8  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry/borrow flag.
- alu_n  in  1  ALU negative flag.
- flag_z  out  1  registered Z flag.
- flag_c  out  1  registered C flag.
- flag_n  out  1  registered N flag.
- done  out  1  one-cycle pulse, high in WB state.
- illegal  out  1  one-cycle pulse in WB for an illegal opcode.
- ld_en  in  1  register load strobe, honoured in IDLE only.
- ld_sel  in  2  register index for the load.
- ld_data  in  8  value to load.
- dbg_sel  in  2  debug register read index.
- dbg_data  out  8  combinational read of R[dbg_sel].

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, R0..R3=REG_RESET, flags=0.
  - done=0, illegal=0, alu_a=alu_b=0, alu_op=0.
  - An instruction in flight is discarded with no writeback; asserting rst mid-operation behaves identically.
- FSM is IDLE -> READ -> EXEC -> WB -> IDLE. One instruction completes every 4 cycles.
- IDLE:
  - instr_ready=1.
  - If instr_valid at edge E0, latch instr and go to READ.
  - Otherwise, if ld_en, R[ld_sel]<=ld_data.
  - When both instr_valid and ld_en are high, the instruction is accepted and ld_en is ignored.
- READ: at E1, opa_q<=R[rd] and opb_q<=R[rs]; go to EXEC.
- EXEC:
  - alu_a=opa_q, alu_b=opb_q, alu_op=opcode; these are registered and stable for the whole cycle.
  - At E2, capture alu_out, alu_z, alu_c and alu_n into res_q/flag_next; go to WB.
- WB:
  - done=1 for this cycle. At E3, write R[rd]<=res_q, update flags, go to IDLE.
  - A new instruction is accepted at E4 at the earliest, and its READ sees the E3 writeback, so no hazards.
- Opcode handling:
  - 0000-0111 (ADD, SUB, INC, DEC, AND, OR, XOR, NOT): result goes to rd. Unary ops use A only; B is ignored.
  - 1000 MOV: R[rd]<=R[rs]; flags unchanged. alu_op is driven 0 and the ALU result is ignored.
  - 1001-1111: illegal. No register write, flags unchanged, illegal=1 during WB.
- Flag update rules:
  - Arithmetic (0000-0011): Z, C and N are all updated.
  - Logic (0100-0111): Z and N are updated; C is cleared to 0.
- rd==rs is legal and both operands read the same register, e.g. ADD R2,R2 doubles R2.
- instr_valid high outside IDLE is ignored; the upstream stage holds it.

Optional Feature:
- Macro: ALU_EXEC_LOCAL_FLAGS_EN.
- Defined:
  - Z and N are computed locally from the captured result: Z=(alu_out==8'h00), N=alu_out[7].
  - alu_z and alu_n are ignored.
  - This gives correct Z/N for INC and the logic ops, whose ALU output does not set them.
- Undefined: Z and N are taken directly from alu_z and alu_n.
- C is always taken from alu_c, whether or not the macro is defined.

Test Plan:
- Load R0=F0, R1=20; ADD R0,R1 -> done in cycle 4 after acceptance; R0=10, C=1, Z=0; instr_ready low for 3 cycles.
- Load R2=55, R3=55; SUB R2,R3 -> R2=00, Z=1, C=0. Then SUB R2,R3 again -> R2=AB, C=1.
- Load R1=FF; INC R1 -> R1=00, C=1. With ALU_EXEC_LOCAL_FLAGS_EN: Z=1, N=0. Without it: Z=alu_z (0 from ALU).
- Load R0=0F; NOT R0 -> R0=F0, C=0. With the macro, N=1.
- Opcode 1010 -> illegal pulses once in WB, registers and flags unchanged. MOV R3,R0 -> R3=R0, flags unchanged.
- Assert rst during EXEC of ADD -> next cycle IDLE, all regs=REG_RESET, flags=0, no done pulse. ld_en in the same cycle as accepted instr_valid -> load ignored.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake and ALU operand/result bus for the execute-stage controller.
// slave: the controller side; master: upstream decoder plus combinational ALU.
interface alu_exec_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       alu_z;
  logic       alu_c;
  logic       alu_n;

  modport slave (
    input  instr_valid, instr, alu_out, alu_z, alu_c, alu_n,
    output instr_ready, alu_a, alu_b, alu_op
  );

  modport master (
    output instr_valid, instr, alu_out, alu_z, alu_c, alu_n,
    input  instr_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller around an 8-bit ALU: IDLE -> READ -> EXEC -> WB, 4x8 register file.
// Optional ALU_EXEC_LOCAL_FLAGS_EN derives Z/N from the captured ALU result instead of alu_z/alu_n.
module alu_exec_ctrl #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] REG_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  alu_exec_ctrl_if.slave    bus,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              done,
  output logic              illegal,
  input  logic              ld_en,
  input  logic [1:0]        ld_sel,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

  state_t state_reg, state_next;

  logic [7:0]        instr_reg;
  logic [DATA_W-1:0] alu_a_reg, alu_b_reg, res_reg;
  logic [3:0]        alu_op_reg;
  logic              cap_z_reg, cap_c_reg, cap_n_reg;
  logic              flag_z_reg, flag_c_reg, flag_n_reg;

  logic [3:0] opcode;
  logic [1:0] rd, rs;
  logic       op_arith, op_logic, op_mov, op_illegal;
  logic       accept, wb_we, ld_we;
  logic       z_src, n_src;

  logic [DATA_W-1:0] reg_q [4];

  assign opcode     = instr_reg[7:4];
  assign rd         = instr_reg[3:2];
  assign rs         = instr_reg[1:0];
  assign op_arith   = (opcode[3:2] == 2'b00);
  assign op_logic   = (opcode[3:2] == 2'b01);
  assign op_mov     = (opcode == 4'b1000);
  assign op_illegal = opcode[3] & ~op_mov;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    accept          = 1'b0;
    wb_we           = 1'b0;
    ld_we           = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    bus.instr_ready = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept     = 1'b1;
          state_next = ST_READ;
        end else begin
          // An accepted instruction takes priority over a same-cycle load
          ld_we = ld_en;
        end
      end
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WB;
      ST_WB: begin
        done       = 1'b1;
        illegal    = op_illegal;
        wb_we      = ~op_illegal;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rf
      logic [DATA_W-1:0] r_reg;
      always_ff @(posedge clk) begin
        if (rst)
          r_reg <= REG_RESET;
        else if (wb_we && (rd == 2'(gi)))
          r_reg <= res_reg;
        else if (ld_we && (ld_sel == 2'(gi)))
          r_reg <= ld_data;
      end
      assign reg_q[gi] = r_reg;
    end
  endgenerate

  assign dbg_data = reg_q[dbg_sel];

`ifdef ALU_EXEC_LOCAL_FLAGS_EN
  assign z_src = (bus.alu_out == '0);
  assign n_src = bus.alu_out[DATA_W-1];
`else
  assign z_src = bus.alu_z;
  assign n_src = bus.alu_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_reg  <= '0;
      alu_a_reg  <= '0;
      alu_b_reg  <= '0;
      alu_op_reg <= '0;
      res_reg    <= '0;
      cap_z_reg  <= 1'b0;
      cap_c_reg  <= 1'b0;
      cap_n_reg  <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_n_reg <= 1'b0;
    end else begin
      if (accept)
        instr_reg <= bus.instr;
      // Operands are presented to the ALU only while in EXEC
      if (state_reg == ST_READ) begin
        alu_a_reg  <= reg_q[rd];
        alu_b_reg  <= reg_q[rs];
        alu_op_reg <= op_mov ? 4'h0 : opcode;
      end else if (state_reg == ST_EXEC) begin
        alu_a_reg  <= '0;
        alu_b_reg  <= '0;
        alu_op_reg <= '0;
        res_reg    <= op_mov ? alu_b_reg : bus.alu_out;
        cap_z_reg  <= z_src;
        cap_c_reg  <= bus.alu_c;
        cap_n_reg  <= n_src;
      end
      if (state_reg == ST_WB) begin
        if (op_arith) begin
          flag_z_reg <= cap_z_reg;
          flag_c_reg <= cap_c_reg;
          flag_n_reg <= cap_n_reg;
        end else if (op_logic) begin
          flag_z_reg <= cap_z_reg;
          flag_c_reg <= 1'b0;
          flag_n_reg <= cap_n_reg;
        end
      end
    end
  end

  assign bus.alu_a  = alu_a_reg;
  assign bus.alu_b  = alu_b_reg;
  assign bus.alu_op = alu_op_reg;
  assign flag_z     = flag_z_reg;
  assign flag_c     = flag_c_reg;
  assign flag_n     = flag_n_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed vector table, randomized instruction stream and mid-op reset,
// with a behavioural ALU and architectural-state model.
module tb_alu_exec_ctrl;

  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef ALU_EXEC_LOCAL_FLAGS_EN
  localparam bit LF = 1'b1;
`else
  localparam bit LF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_z, flag_c, flag_n, done, illegal;
  logic       ld_en;
  logic [1:0] ld_sel;
  logic [7:0] ld_data;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mdl_r [4];
  logic [2:0] mdl_f;

  always #5 clk = ~clk;

  alu_exec_ctrl_if bus ();

  alu_exec_ctrl #(.DATA_W(8), .REG_RESET(RST_VAL)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .done(done), .illegal(illegal),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // Behavioural ALU; INC and logic ops leave Z/N low, logic ops put junk on C.
  function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic z, c, n;
    r = a ^ b; z = 1'b1; c = 1'b1; n = 1'b1;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; z = (r == 8'h00); n = r[7]; end
      4'd1: begin r = a - b; c = (a < b); z = (r == 8'h00); n = r[7]; end
      4'd2: begin s = {1'b0, a} + 9'd1; r = s[7:0]; c = s[8]; z = 1'b0; n = 1'b0; end
      4'd3: begin r = a - 8'd1; c = (a == 8'h00); z = (r == 8'h00); n = r[7]; end
      4'd4: begin r = a & b; c = a[0]; z = 1'b0; n = 1'b0; end
      4'd5: begin r = a | b; c = a[0]; z = 1'b0; n = 1'b0; end
      4'd6: begin r = a ^ b; c = a[0]; z = 1'b0; n = 1'b0; end
      4'd7: begin r = ~a;    c = a[0]; z = 1'b0; n = 1'b0; end
      default: ;
    endcase
    return {r, z, c, n};
  endfunction

  always_comb {bus.alu_out, bus.alu_z, bus.alu_c, bus.alu_n} = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_dbg(input logic [1:0] s, output logic [7:0] d);
    dbg_sel = s;
    #1;
    d = dbg_data;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      read_dbg(2'(i), d);
      chk({tag, "_reg"}, 32'(d), 32'(mdl_r[i]));
    end
    chk({tag, "_flags"}, 32'({flag_z, flag_c, flag_n}), 32'(mdl_f));
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] data);
    ld_en = 1'b1; ld_sel = sel; ld_data = data;
    step();
    ld_en = 1'b0;
    mdl_r[sel] = data;
  endtask

  task automatic model_exec(input logic [7:0] ins);
    logic [3:0] opc;
    logic [7:0] r;
    logic z, c, n;
    opc = ins[7:4];
    if (!opc[3]) begin
      {r, z, c, n} = alu_ref(opc, mdl_r[ins[3:2]], mdl_r[ins[1:0]]);
      if (LF) begin
        z = (r == 8'h00);
        n = r[7];
      end
      if (opc >= 4'd4) c = 1'b0;
      mdl_r[ins[3:2]] = r;
      mdl_f = {z, c, n};
    end else if (opc == 4'd8) begin
      mdl_r[ins[3:2]] = mdl_r[ins[1:0]];
    end
  endtask

  task automatic run_instr(input logic [7:0] ins, input logic acc_ld, input logic [1:0] acc_sel,
                           input logic [7:0] acc_data, input logic hold_valid, input logic noisy_ld);
    logic [3:0] rdy, dn, il;
    logic       exp_ill;
    logic [7:0] exp_a, exp_b;
    logic [3:0] exp_op;
    exp_ill = ins[7] && (ins[7:4] != 4'd8);
    exp_a   = mdl_r[ins[3:2]];
    exp_b   = mdl_r[ins[1:0]];
    exp_op  = (ins[7:4] == 4'd8) ? 4'd0 : ins[7:4];
    bus.instr_valid = 1'b1; bus.instr = ins;
    ld_en = acc_ld; ld_sel = acc_sel; ld_data = acc_data;
    chk("ready_idle", 32'(bus.instr_ready), 32'(1));
    step();
    for (int k = 0; k < 4; k++) begin
      rdy[k] = bus.instr_ready; dn[k] = done; il[k] = illegal;
      if (k == 1) begin
        chk("exec_alu_a", 32'(bus.alu_a), 32'(exp_a));
        chk("exec_alu_b", 32'(bus.alu_b), 32'(exp_b));
        if (!exp_ill) chk("exec_alu_op", 32'(bus.alu_op), 32'(exp_op));
      end
      if (k < 3) begin
        if (hold_valid) bus.instr = 8'($urandom);
        else            bus.instr_valid = 1'b0;
        ld_en   = noisy_ld ? 1'($urandom) : 1'b0;
        ld_sel  = 2'($urandom);
        ld_data = 8'($urandom);
        step();
      end
    end
    bus.instr_valid = 1'b0; ld_en = 1'b0;
    chk("ready_seq", 32'(rdy), 32'(4'b1000));
    chk("done_seq", 32'(dn), 32'(4'b0100));
    chk("illegal_seq", 32'(il), exp_ill ? 32'(4'b0100) : 32'(0));
    model_exec(ins);
    $display("TXN instr=%02h rd=%0d val=%02h zcn=%b illegal=%0b", ins, ins[3:2], mdl_r[ins[3:2]], mdl_f, exp_ill);
    check_all("txn");
  endtask

  typedef struct packed {
    logic [3:0]  ld_mask;
    logic [31:0] ld_val;   // {R3,R2,R1,R0}
    logic [7:0]  ins;
    logic        acc_ld;
    logic [7:0]  exp_rd;
    logic [2:0]  exp_zcn;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] d;
    logic [3:0] dseq;
    vecs[0] = '{4'b0011, 32'h0000_20F0, 8'h01, 1'b0, 8'h10, 3'b010};
    vecs[1] = '{4'b1100, 32'h5555_0000, 8'h1B, 1'b0, 8'h00, 3'b100};
    vecs[2] = '{4'b0000, 32'h0,         8'h1B, 1'b0, 8'hAB, 3'b011};
    vecs[3] = '{4'b0010, 32'h0000_FF00, 8'h25, 1'b0, 8'h00, LF ? 3'b110 : 3'b010};
    vecs[4] = '{4'b0001, 32'h0000_000F, 8'h70, 1'b0, 8'hF0, LF ? 3'b001 : 3'b000};
    vecs[5] = '{4'b0000, 32'h0,         8'hA4, 1'b0, 8'h00, LF ? 3'b001 : 3'b000};
    vecs[6] = '{4'b0000, 32'h0,         8'h8C, 1'b0, 8'hF0, LF ? 3'b001 : 3'b000};
    vecs[7] = '{4'b0000, 32'h0,         8'h40, 1'b1, 8'hF0, LF ? 3'b001 : 3'b000};

    bus.instr_valid = 1'b0; bus.instr = 8'h00;
    ld_en = 1'b0; ld_sel = 2'd0; ld_data = 8'h00; dbg_sel = 2'd0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl_r[i] = RST_VAL;
    mdl_f = 3'b000;
    chk("rst_ready", 32'(bus.instr_ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_illegal", 32'(illegal), 32'(0));
    chk("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(0));
    check_all("rst");

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++)
        if (vecs[v].ld_mask[i]) load(2'(i), vecs[v].ld_val[8*i +: 8]);
      run_instr(vecs[v].ins, vecs[v].acc_ld, 2'd2, 8'hEE, 1'b0, 1'b0);
      read_dbg(vecs[v].ins[3:2], d);
      chk("tbl_rd", 32'(d), 32'(vecs[v].exp_rd));
      chk("tbl_flags", 32'({flag_z, flag_c, flag_n}), 32'(vecs[v].exp_zcn));
    end

    for (int t = 0; t < 150; t++) begin
      int nld;
      logic [3:0] opc;
      nld = $urandom_range(0, 2);
      for (int j = 0; j < nld; j++) load(2'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) step();
      opc = 4'($urandom_range(0, 11));
      run_instr({opc, 4'($urandom)}, 1'($urandom), 2'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));
    end

    // Reset while an ADD sits in EXEC: no writeback, no done pulse
    load(2'd0, 8'h33);
    load(2'd1, 8'h44);
    bus.instr_valid = 1'b1; bus.instr = 8'h01;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("mid_exec_alu_a", 32'(bus.alu_a), 32'(8'h33));
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) mdl_r[i] = RST_VAL;
    mdl_f = 3'b000;
    dseq = {2'b00, illegal, done};
    chk("rst_mid_ready", 32'(bus.instr_ready), 32'(1));
    chk("rst_mid_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'(0));
    check_all("rst_mid");
    step();
    dseq[2] = done;
    step();
    dseq[3] = done;
    chk("rst_mid_no_done", 32'(dseq), 32'(0));
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
